// File: rtl/cva6_bht_pkg.sv
// Shared types and helpers for the local-history BHT (cva6_bht_lhist).
// Optional same-cycle update forwarding is enabled by CVA6_BHT_UPDATE_BYPASS_EN.
package cva6_bht_pkg;

   // Storage is sized for the largest history; narrower builds leave upper slots unused.
   localparam int unsigned MAX_HIST_BITS = 4;
   localparam int unsigned MAX_CNT       = 1 << MAX_HIST_BITS;

   localparam logic [1:0] CNT_RST = 2'b01;

   typedef struct packed {
      logic                          valid;
      logic [MAX_HIST_BITS-1:0]      hist;
      logic [MAX_CNT-1:0][1:0]       cnt;
   } bht_lhist_entry_t;

   typedef enum logic [1:0] {
      RESET,
      INIT,
      READY
   } bht_fsm_e;

   localparam bht_lhist_entry_t BHT_INIT_ENTRY = '{
      valid: 1'b0,
      hist:  '0,
      cnt:   {MAX_CNT{CNT_RST}}
   };

   function automatic logic [1:0] sat_cnt_upd(input logic [1:0] c, input logic taken);
      if (taken) begin
         return (c == 2'b11) ? c : c + 2'b01;
      end else begin
         return (c == 2'b00) ? c : c - 2'b01;
      end
   endfunction

endpackage

// File: rtl/cva6_bht_lhist_upd.sv
// Next-entry computation for one resolved branch (shared by update and bypass paths).
// Used unchanged whether or not CVA6_BHT_UPDATE_BYPASS_EN is defined.
module cva6_bht_lhist_upd
   import cva6_bht_pkg::*;
#(
   parameter int unsigned HIST_BITS = 3
) (
   input  bht_lhist_entry_t cur_entry,
   input  logic             taken,
   output bht_lhist_entry_t nxt_entry
);

   localparam logic [MAX_HIST_BITS-1:0] HIST_MASK = MAX_HIST_BITS'((1 << HIST_BITS) - 1);

   logic [MAX_HIST_BITS-1:0] sel;

   always_comb begin
      nxt_entry = cur_entry;
      sel       = cur_entry.hist & HIST_MASK;
      nxt_entry.cnt[sel] = sat_cnt_upd(cur_entry.cnt[sel], taken);
      // Masking keeps the unused upper history bits at zero for narrow builds.
      nxt_entry.hist  = {cur_entry.hist[MAX_HIST_BITS-2:0], taken} & HIST_MASK;
      nxt_entry.valid = 1'b1;
   end

endmodule

// File: rtl/cva6_bht_lhist.sv
// Local-history BHT: per-entry history selects one of 2^HIST_BITS 2-bit counters.
// Define CVA6_BHT_UPDATE_BYPASS_EN to forward a same-cycle update into lookup.
module cva6_bht_lhist
   import cva6_bht_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = 32,
   parameter int unsigned HIST_BITS  = 3,
   parameter int unsigned NR_PORTS   = 2,
   parameter int unsigned VLEN       = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic [NR_PORTS-1:0][VLEN-1:0]  vpc_i,
   output logic [NR_PORTS-1:0]            pred_valid_o,
   output logic [NR_PORTS-1:0]            pred_taken_o,
   input  logic                           upd_valid_i,
   input  logic [VLEN-1:0]                upd_pc_i,
   input  logic                           upd_taken_i,
   output logic                           init_done_o
);

   localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

   // Handshake: no backpressure anywhere. An update is consumed in the cycle
   // upd_valid_i is high if the FSM is READY and no flush is requested;
   // otherwise it is silently dropped. Lookups are combinational and always answered.

   bht_fsm_e          state_q, state_d;
   logic [IDX_W-1:0]  sweep_q, sweep_d;
   bht_lhist_entry_t  tbl_q [NR_ENTRIES];

   logic              init_we;
   logic              upd_fire;
   logic [IDX_W-1:0]  upd_idx;
   bht_lhist_entry_t  upd_cur, upd_next;
   logic              unused_pc_bits;

   // Only the low index bits (above the RVC-aligned bit 0) address the table.
   assign unused_pc_bits = ^{vpc_i, upd_pc_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RESET;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      init_we = 1'b0;
      unique case (state_q)
         RESET: begin
            state_d = INIT;
            sweep_d = '0;
         end
         INIT: begin
            init_we = 1'b1;
            if (flush_i) begin
               sweep_d = '0;
            end else if (sweep_q == LAST_IDX) begin
               state_d = READY;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         READY: begin
            if (flush_i) begin
               state_d = INIT;
               sweep_d = '0;
            end
         end
         default: begin
            state_d = RESET;
            sweep_d = '0;
         end
      endcase
   end

   assign init_done_o = (state_q == READY);
   assign upd_fire    = upd_valid_i & init_done_o & ~flush_i;
   assign upd_idx     = upd_pc_i[IDX_W:1];
   assign upd_cur     = tbl_q[upd_idx];

   cva6_bht_lhist_upd #(
      .HIST_BITS (HIST_BITS)
   ) i_upd (
      .cur_entry (upd_cur),
      .taken     (upd_taken_i),
      .nxt_entry (upd_next)
   );

   // The array has no reset; the INIT sweep clears it one entry per cycle.
   always_ff @(posedge clk_i) begin
      if (init_we) begin
         tbl_q[sweep_q] <= BHT_INIT_ENTRY;
      end else if (upd_fire) begin
         tbl_q[upd_idx] <= upd_next;
      end
   end

   always_comb begin : lookup
      logic [IDX_W-1:0] idx;
      bht_lhist_entry_t e;
      pred_valid_o = '0;
      pred_taken_o = '0;
      idx          = '0;
      e            = BHT_INIT_ENTRY;
      for (int p = 0; p < NR_PORTS; p++) begin
         idx = vpc_i[p][IDX_W:1];
         e   = tbl_q[idx];
`ifdef CVA6_BHT_UPDATE_BYPASS_EN
         if (upd_fire && (upd_idx == idx)) begin
            e = upd_next;
         end
`endif
         pred_valid_o[p] = init_done_o & e.valid;
         pred_taken_o[p] = init_done_o & e.cnt[e.hist][1];
      end
   end

endmodule

// File: tb/tb_cva6_bht_lhist.sv
// Directed scoreboard bench for cva6_bht_lhist (default parameters).
// Expectations follow CVA6_BHT_UPDATE_BYPASS_EN when the bench is built with it.
module tb_cva6_bht_lhist;

   localparam int W         = 5;   // {init_done, pred_valid[1:0], pred_taken[1:0]}
   localparam int N_ENT     = 32;
   localparam logic [31:0] PC2  = 32'h8000_0004;  // index 2
   localparam logic [31:0] PC2B = 32'h8000_0044;  // index 2 (aliased)
   localparam logic [31:0] PC4  = 32'h8000_0008;  // index 4
   localparam logic [31:0] PC6  = 32'h8000_000C;  // index 6
`ifdef CVA6_BHT_UPDATE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_i;
   logic             flush_i;
   logic [1:0][31:0] vpc_i;
   logic [1:0]       pred_valid_o;
   logic [1:0]       pred_taken_o;
   logic             upd_valid_i;
   logic [31:0]      upd_pc_i;
   logic             upd_taken_i;
   logic             init_done_o;

   logic [W-1:0]     exp_q[$];
   string            name_q[$];
   logic             chk = 1'b0;
   int               n_checks = 0;
   int               n_fail = 0;

   cva6_bht_lhist dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .vpc_i        (vpc_i),
      .pred_valid_o (pred_valid_o),
      .pred_taken_o (pred_taken_o),
      .upd_valid_i  (upd_valid_i),
      .upd_pc_i     (upd_pc_i),
      .upd_taken_i  (upd_taken_i),
      .init_done_o  (init_done_o)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required end within 200000 time units");
      $fatal(1);
   end

   // scoreboard monitor: samples on the falling edge whenever a check is posted
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string        nm;
      if (chk) begin
         n_checks++;
         got = {init_done_o, pred_valid_o, pred_taken_o};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expect: got %b, required a queued expectation", got);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s: got %b, required %b (done,valid[1:0],taken[1:0])", nm, got, e);
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   task automatic check(input logic [W-1:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      chk = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken);
      upd_valid_i = 1'b1;
      upd_pc_i    = pc;
      upd_taken_i = taken;
   endtask

   task automatic reset_seq();
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      upd_valid_i = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check(5'b0_00_00, "in_reset");
         step();
      end
      rst_i = 1'b0;
      // cycle 1 is the first with reset low; READY must appear on cycle N_ENT+2
      for (int k = 1; k <= N_ENT + 2; k++) begin
         check((k == N_ENT + 2) ? 5'b1_00_00 : 5'b0_00_00, "init_seq");
         step();
      end
   endtask

   logic dir_v [5];
   logic exp_t [5];

   initial begin
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      upd_valid_i = 1'b0;
      upd_pc_i    = '0;
      upd_taken_i = 1'b0;
      vpc_i[0]    = PC2;
      vpc_i[1]    = PC2B;

      reset_seq();

      // first update on index 2
      upd(PC2, 1'b1);
      check(BYP ? 5'b1_11_00 : 5'b1_00_00, "upd_same_cycle");
      step();
      upd_valid_i = 1'b0;
      check(5'b1_11_00, "first_upd");
      step();

      // eight taken updates, then one more to show saturation
      for (int i = 0; i < 8; i++) begin
         upd(PC2, 1'b1);
         step();
      end
      upd_valid_i = 1'b0;
      check(5'b1_11_11, "hist_taken8");
      step();
      upd(PC2, 1'b1);
      step();
      upd_valid_i = 1'b0;
      check(5'b1_11_11, "cnt_sat_high");
      step();

      // ports looking at different indices
      vpc_i[1] = PC4;
      check(5'b1_01_01, "port_indep");
      step();
      vpc_i[1] = PC2B;

      // decrement / floor-saturation walk through the counter array
      dir_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         upd(PC2, dir_v[i]);
         step();
         upd_valid_i = 1'b0;
         check({3'b1_11, exp_t[i], exp_t[i]}, "dir_walk");
         step();
      end

      // same-cycle update and lookup with differing pre/post predictions
      upd(PC2, 1'b1);
      check(BYP ? 5'b1_11_00 : 5'b1_11_11, "bypass_cycle");
      step();
      upd_valid_i = 1'b0;
      check(5'b1_11_00, "bypass_next");
      step();

      // flush together with an update: update dropped, INIT updates ignored
      vpc_i[1] = PC4;
      flush_i  = 1'b1;
      upd(PC4, 1'b1);
      check(5'b1_01_00, "flush_cycle");
      step();
      flush_i = 1'b0;
      upd(PC6, 1'b1);
      for (int k = 1; k <= N_ENT; k++) begin
         if (k == N_ENT) upd_valid_i = 1'b0;
         check(5'b0_00_00, "flush_init");
         step();
      end
      check(5'b1_00_00, "flush_done");
      step();
      vpc_i[1] = PC6;
      check(5'b1_00_00, "init_upd_ignored");
      step();

      vpc_i[1] = PC4;
      upd(PC4, 1'b1);
      step();
      upd_valid_i = 1'b0;
      check(5'b1_10_00, "post_flush_upd");
      step();

      // reset in the middle of a sweep restarts the whole sequence
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset_seq();

      step();
      step();
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cva6_bht_lhist.md
# cva6_bht_lhist

Local-history branch history table for the CVA6 frontend, the parametrised successor of the plain 2-bit BHT. Each entry holds an N-bit per-branch history and 2^N saturating 2-bit counters selected by that history. Multiple prediction ports serve superscalar fetch. A sweep FSM clears the arrays after reset or flush without a wide reset fan-out. The block sits between frontend PC generation (lookup) and the branch unit (resolution update).

## Interface
Parameters:
- NR_ENTRIES, 32: table entries; power of two, ≥2.
- HIST_BITS, 3: per-entry history length; 1..4.
- NR_PORTS, 2: parallel prediction ports.
- VLEN, 32: virtual PC width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock domain; reset is synchronous and active-high.
- flush_i  in  1  request a full table clear.
- vpc_i  in  NR_PORTS×VLEN  lookup PCs, one per port.
- pred_valid_o  out  NR_PORTS  per-port prediction valid.
- pred_taken_o  out  NR_PORTS  per-port predicted direction.
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  VLEN  resolved branch PC.
- upd_taken_i  in  1  resolved direction.
- init_done_o  out  1  high when the table is usable.

## Operation
- Index is vpc[IDX_W:1], where IDX_W = log2(NR_ENTRIES). Bit 0 is ignored because the core is RVC-aligned.
- Each entry holds three fields:
  - valid bit.
  - hist[HIST_BITS-1:0].
  - cnt[2^HIST_BITS] of 2 bits each.
- Lookup is combinational from registered state:
  - pred_valid_o[p] = init_done_o & entry.valid.
  - pred_taken_o[p] = entry.cnt[entry.hist][1].
  - All ports may hit the same index.
- Update runs only when upd_valid_i is high and the FSM is in READY.
  - Counter c = cnt[hist] saturates: taken gives min(c+1,3); not-taken gives max(c-1,0).
  - History becomes {hist[HIST_BITS-2:0], upd_taken_i}.
  - valid is set to 1.
  - All three fields are written in one cycle.
- FSM states: RESET, INIT, READY.
  - RESET is entered while rst_i is high. It moves to INIT on the first cycle with rst_i low.
  - INIT sweeps a counter from 0 to NR_ENTRIES-1, one entry per cycle. Each written entry gets valid=0, hist=0, all cnt=2'b01 (weakly not-taken). After writing entry NR_ENTRIES-1 the FSM moves to READY.
  - READY asserts init_done_o. flush_i moves the FSM to INIT with the sweep counter at 0.
- Boundary rules:
  - flush_i and upd_valid_i in the same READY cycle: flush wins and the update is dropped.
  - flush_i during INIT restarts the sweep at 0.
  - rst_i at any time forces RESET. An in-progress sweep is abandoned.
  - upd_valid_i during RESET or INIT is ignored.
  - Update and lookup to the same index in the same cycle: lookup returns pre-update state, unless the bypass feature under Configuration is compiled in.

## Timing
- Reset values: init_done_o=0, pred_valid_o=0, pred_taken_o=0. The FSM is in RESET and the sweep counter is 0.
- init_done_o rises exactly NR_ENTRIES+1 cycles after the first cycle with rst_i low: 1 cycle in RESET, then NR_ENTRIES cycles of INIT.
- After flush_i is sampled in READY, init_done_o is low from the next cycle for NR_ENTRIES cycles.
- Lookup latency: 0 cycles (combinational).
- Update latency: the write is visible to lookup the cycle after upd_valid_i.
- There is no backpressure. Updates are fire-and-forget.

## Configuration
- Macro: CVA6_BHT_UPDATE_BYPASS_EN.
- Defined: a same-cycle update to the looked-up index is forwarded to lookup.
  - pred_taken_o reflects the post-update counter selected by the post-update history.
  - pred_valid_o=1 while READY.
- Undefined: no forwarding. Lookup always reads registered state.

## Structure
- Shared package cva6_bht_pkg holds:
  - bht_lhist_entry_t struct: valid, hist, cnt array.
  - bht_fsm_e enum: RESET, INIT, READY.
  - Constants: counter reset value 2'b01, the helper function for saturating counter update.
- Sub-module: cva6_bht_lhist_upd.
  - Purely combinational.
  - Takes an entry and a direction and returns the next entry.
  - Used by the update path and by the bypass path.

## Test plan
- Reset release → init_done_o=0 for 33 cycles, 1 on cycle 34 (defaults). Every pred_valid_o is 0 throughout.
- Defaults, one update with pc 0x80000004 (index 2) taken=1 → entry 2 becomes valid=1, hist=3'b001, cnt[0]=2'b10. Lookup of 0x80000004 then gives valid=1, taken=0 (cnt[1]=01).
- Eight consecutive taken updates at index 2 → hist=3'b111, cnt[7]=2'b11, taken=1. A ninth taken update → cnt[7] stays 2'b11 (saturation).
- Port 0 at 0x80000004 and port 1 at 0x80000044, both index 2 → identical predictions on both ports.
- flush_i in READY together with upd_valid_i → update dropped. init_done_o is low for 32 cycles, then all entries are invalid.
- Bypass build, update index 2 taken while looking up index 2 → taken reflects new state in the same cycle. Non-bypass build → old state in that cycle, new state on the next.
